// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Purpose:
//   Writer side of the instruction-memory port. Receives a program image from
//   a host byte channel (UART RX / debug FIFO) and writes it word by word into
//   imem. The frame is a little-endian 16-bit word count N followed by N*4
//   data bytes, each word little-endian (first byte lands in [7:0]). While a
//   load is running the CPU is held in reset through cpu_hold. done is raised
//   once the whole image is written.
//
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   start        1-cycle pulse that arms a new load from IDLE, DONE or ERROR
//   byte_valid   host byte present on byte_data
//   byte_data    host byte
//   byte_ready   loader takes byte_data this cycle (transfer = valid && ready)
//   imem_we      imem write strobe, one cycle per word
//   imem_addr    imem word address (meaningful only while imem_we is high)
//   imem_wdata   assembled word     (meaningful only while imem_we is high)
//   cpu_hold     OR into the CPU reset; high while a load is in progress
//   busy         load in progress
//   done         level, image fully written
//   error        level, header word count exceeds imem capacity
//   word_count   words written so far in the current load
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int BUS_WIDTH  = 10,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  imem_we,
    output logic [BUS_WIDTH-1:0]  imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [LEN_WIDTH-1:0]  word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    // One extra bit so that a full-capacity image (N == 2**BUS_WIDTH) is
    // representable in the comparison even when BUS_WIDTH == LEN_WIDTH.
    localparam logic [LEN_WIDTH:0] CAPACITY = (LEN_WIDTH+1)'(1) << BUS_WIDTH;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  new_len;
    logic [1:0]            idx_q, idx_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [LEN_WIDTH-1:0]  word_count_q, word_count_d;
    logic [BUS_WIDTH-1:0]  imem_addr_q, imem_addr_d;
    logic [DATA_WIDTH-1:0] imem_wdata_q, imem_wdata_d;
    logic                  byte_ready_q, byte_ready_d;
    logic                  imem_we_q, imem_we_d;
    logic                  cpu_hold_q, cpu_hold_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  xfer;

    // Next-state logic. All status outputs are decoded from the next state so
    // that, once registered, they line up exactly with the state they describe.
    // byte_ready is registered too, so a transfer is judged against the value
    // the host saw during this cycle.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        idx_d        = idx_q;
        word_d       = word_q;
        word_count_d = word_count_q;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        xfer         = byte_valid && byte_ready_q;
        new_len      = len_q;
        new_len[15:8] = byte_data;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d      = S_LEN_LO;
                    word_count_d = '0;
                    idx_d        = '0;
                    len_d        = '0;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_d[7:0] = byte_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    len_d = new_len;
                    idx_d = '0;
                    if (new_len == '0) begin
                        state_d = S_DONE;
                    end else if ({1'b0, new_len} > CAPACITY) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    word_d[{idx_q, 3'b000} +: 8] = byte_data;
                    idx_d = idx_q + 2'd1;
                    // The write address and data are latched here so the
                    // strobe cycle presents a stable, complete word.
                    if (idx_q == 2'd3) begin
                        state_d      = S_WRITE;
                        imem_addr_d  = word_count_q[BUS_WIDTH-1:0];
                        imem_wdata_d = word_d;
                    end
                end
            end
            S_WRITE: begin
                word_count_d = word_count_q + LEN_WIDTH'(1);
                idx_d        = '0;
                if (word_count_d == len_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DATA;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        byte_ready_d = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
                       (state_d == S_DATA);
        busy_d       = byte_ready_d || (state_d == S_WRITE);
        cpu_hold_d   = busy_d;
        imem_we_d    = (state_d == S_WRITE);
        done_d       = (state_d == S_DONE);
        error_d      = (state_d == S_ERROR);
    end

    // State and output registers; reset leaves imem contents alone since the
    // loader only ever drives the write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            idx_q        <= '0;
            word_q       <= '0;
            word_count_q <= '0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            byte_ready_q <= 1'b0;
            imem_we_q    <= 1'b0;
            cpu_hold_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            word_q       <= word_d;
            word_count_q <= word_count_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            byte_ready_q <= byte_ready_d;
            imem_we_q    <= imem_we_d;
            cpu_hold_q   <= cpu_hold_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//
// Purpose:
//   Self-checking bench for imem_loader. A table of frame headers with their
//   expected final status is replayed with random payload bytes and random
//   host gaps; the expected imem writes come from a reference model that
//   simply slices the sent byte stream into little-endian words. Hand-written
//   sequences cover reset, write latency, start-while-busy and reset mid-load.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_imem_loader;

    localparam int DW = 32;
    localparam int BW = 10;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          imem_we;
    logic [BW-1:0] imem_addr;
    logic [DW-1:0] imem_wdata;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          error;
    logic [LW-1:0] word_count;

    int total = 0;
    int bad   = 0;

    imem_loader #(.DATA_WIDTH(DW), .BUS_WIDTH(BW), .LEN_WIDTH(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    // Write log and hold-consistency monitor, sampled mid-cycle.
    logic [BW-1:0] wr_addr[$];
    logic [DW-1:0] wr_data[$];
    int            hold_bad = 0;

    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
            if (!cpu_hold) hold_bad++;
        end
        if (cpu_hold != busy) hold_bad++;
    end

    // Bytes the bench has pushed into the data phase of the current frame.
    logic [7:0] sent[$];

    typedef struct {
        logic [7:0] len_lo;
        logic [7:0] len_hi;
        int         gap_max;
        bit         exp_done;
        bit         exp_error;
        int         exp_words;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Offer one byte after a host gap and hold it until the loader takes it.
    task automatic sendByte(input logic [7:0] b, input int gap);
        byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        for (int t = 0; t < 100 && !byte_ready; t++) @(negedge clk);
        if (!byte_ready) begin
            total++;
            bad++;
            $display("[TB] FAIL byte_timeout actual=ready0 expected=ready1");
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    // A stray valid byte rides along with start; the loader must not take it.
    task automatic applyStimulus();
        wr_addr.delete();
        wr_data.delete();
        sent.delete();
        hold_bad   = 0;
        start      = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'hA5;
        @(negedge clk);
        start      = 1'b0;
        byte_valid = 1'b0;
    endtask

    task automatic sendData(input logic [7:0] b, input int gap);
        sent.push_back(b);
        sendByte(b, gap);
    endtask

    task automatic waitEnd();
        for (int t = 0; t < 50 && !(done || error); t++) @(negedge clk);
        if (!(done || error)) begin
            total++;
            bad++;
            $display("[TB] FAIL end_timeout actual=running expected=finished");
        end
    endtask

    // Reference: the i-th write must go to address i and carry bytes 4i..4i+3
    // of the payload, little-endian.
    task automatic checkWrites(input string name);
        int mism;
        int n;
        logic [DW-1:0] exp_word;
        mism = 0;
        n = sent.size() / 4;
        checkOutput({name, "_nwrites"}, 64'(wr_addr.size()), 64'(n));
        for (int i = 0; i < n && i < wr_addr.size(); i++) begin
            exp_word = {sent[4*i+3], sent[4*i+2], sent[4*i+1], sent[4*i]};
            if (wr_addr[i] != BW'(i) || wr_data[i] != exp_word) mism++;
        end
        checkOutput({name, "_write_mism"}, 64'(mism), 64'd0);
        checkOutput({name, "_hold_bad"}, 64'(hold_bad), 64'd0);
    endtask

    initial begin
        int n;
        logic [15:0] hdr;

        vecs[0] = '{8'h01, 8'h00, 0, 1'b1, 1'b0, 1};
        vecs[1] = '{8'h00, 8'h00, 1, 1'b1, 1'b0, 0};
        vecs[2] = '{8'h01, 8'h04, 0, 1'b0, 1'b1, 0};
        vecs[3] = '{8'h03, 8'h00, 3, 1'b1, 1'b0, 3};
        vecs[4] = '{8'hFF, 8'hFF, 1, 1'b0, 1'b1, 0};
        vecs[5] = '{8'h05, 8'h00, 2, 1'b1, 1'b0, 5};
        vecs[6] = '{8'h00, 8'h04, 0, 1'b1, 1'b0, 1024};
        vecs[7] = '{8'h02, 8'h00, 1, 1'b1, 1'b0, 2};

        rst        = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (2) @(negedge clk);
        checkOutput("reset_outputs",
                    {byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, error, word_count},
                    '0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_status", {byte_ready, busy, cpu_hold, done, error}, 5'b0);

        // Single word: write must appear the cycle after the 4th byte.
        $display("[TB] single word frame");
        applyStimulus();
        checkOutput("armed_status", {busy, cpu_hold, byte_ready, done, error}, 5'b11100);
        sendByte(8'h01, 0);
        sendByte(8'h00, 0);
        // A start during the load must not restart the frame.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sendData(8'h78, 0);
        sendData(8'h56, 1);
        sendData(8'h34, 0);
        sendData(8'h12, 2);
        checkOutput("write_latency", {imem_we, imem_addr, imem_wdata}, {1'b1, 10'h000, 32'h12345678});
        waitEnd();
        checkOutput("single_end", {done, error, cpu_hold, busy}, 4'b1000);
        checkWrites("single");

        // Empty image finishes the cycle after len_hi.
        $display("[TB] empty image timing");
        applyStimulus();
        sendByte(8'h00, 0);
        sendByte(8'h00, 0);
        checkOutput("empty_done_now", {done, busy, imem_we}, 3'b100);

        // Table-driven frames with random payloads and host gaps.
        foreach (vecs[v]) begin
            $display("[TB] vector %0d header %02h %02h", v, vecs[v].len_lo, vecs[v].len_hi);
            applyStimulus();
            checkOutput("start_clears", {done, error, busy, word_count}, {3'b001, 16'h0});
            sendByte(vecs[v].len_lo, $urandom_range(0, vecs[v].gap_max));
            sendByte(vecs[v].len_hi, $urandom_range(0, vecs[v].gap_max));
            hdr = {vecs[v].len_hi, vecs[v].len_lo};
            n = int'(hdr);
            if (n <= (1 << BW)) begin
                for (int i = 0; i < 4 * n; i++)
                    sendData(8'($urandom), $urandom_range(0, vecs[v].gap_max));
            end
            waitEnd();
            checkOutput("vec_done", done, vecs[v].exp_done);
            checkOutput("vec_error", error, vecs[v].exp_error);
            checkOutput("vec_hold", {cpu_hold, busy}, 2'b00);
            checkOutput("vec_word_count", word_count, 16'(vecs[v].exp_words));
            checkWrites("vec");
        end

        // Reset after two data bytes, then a clean reload.
        $display("[TB] reset mid-load");
        applyStimulus();
        sendByte(8'h01, 0);
        sendByte(8'h00, 0);
        sendByte(8'hAA, 0);
        sendByte(8'hBB, 0);
        rst = 1'b1;
        #1;
        checkOutput("midload_reset",
                    {byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, error, word_count},
                    '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus();
        sendByte(8'h01, 0);
        sendByte(8'h00, 0);
        sendData(8'h11, 0);
        sendData(8'h22, 0);
        sendData(8'h33, 0);
        sendData(8'h44, 0);
        waitEnd();
        checkOutput("reload_done", {done, error, word_count}, {2'b10, 16'd1});
        checkWrites("reload");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
